// File: rtl/iq_pkg.sv
// iq_pkg: payload field positions shared by Rename, issue queue and RF
package iq_pkg;
  localparam int TAG_W   = 6;
  localparam int RDY1    = 82;
  localparam int TAG1_HI = 81;
  localparam int TAG1_LO = 76;
  localparam int RDY2    = 89;
  localparam int TAG2_HI = 88;
  localparam int TAG2_LO = 83;
  localparam int IMMSRC  = 97;
  localparam int MEMRD   = 98;
  localparam int MEMWR   = 99;
  localparam int PCA_HI  = 136;
  localparam int PCA_LO  = 105;
endpackage

// File: rtl/iq_entry.sv
// iq_entry: one queue slot with tag wakeup and hold/shift/push next-value mux
module iq_entry import iq_pkg::*; #(
  parameter int W = 137
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             wakeup_flag_IN,
  input  logic [TAG_W-1:0] wakeup_index_IN,
  input  logic             shift,
  input  logic             write,
  input  logic [W-1:0]     up_data,
  input  logic             up_valid,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     data,
  output logic [W-1:0]     woken,
  output logic             valid,
  output logic             ready
);
  function automatic logic [W-1:0] wake(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
    if (wakeup_flag_IN && p[TAG1_HI:TAG1_LO] == wakeup_index_IN) r[RDY1] = 1'b1;
    if (wakeup_flag_IN && p[TAG2_HI:TAG2_LO] == wakeup_index_IN) r[RDY2] = 1'b1;
    return r;
  endfunction
  assign woken = wake(data);
  assign ready = valid & data[RDY1] & (data[RDY2] | data[IMMSRC]);
  // occupancy: push write wins over shift-from-above, flush clears
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) valid <= 1'b0;
    else valid <= !FLUSH && (write || (shift ? up_valid : valid));
  // payload: incoming values carry this cycle's wakeup so no broadcast is missed
  always_ff @(posedge CLK)
    data <= write ? wake(push_data) : shift ? up_data : woken;
endmodule

// File: rtl/issue_queue.sv
// issue_queue: collapsing issue queue selecting the oldest ready entry for RF
module issue_queue import iq_pkg::*; #(
  parameter int RENISS_WIDTH = 137,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FREEZE,
  input  logic                    FLUSH,
  input  logic                    push_IN,
  input  logic [RENISS_WIDTH-1:0] pushData_IN,
  output logic                    full_OUT,
  output logic [CNT_W-1:0]        count_OUT,
  input  logic                    wakeup_flag_IN,
  input  logic [TAG_W-1:0]        wakeup_index_IN,
  output logic [RENISS_WIDTH-1:0] IQLSQ_popData_OUT,
  output logic                    Valid_Instruction_OUT,
  output logic                    Mem_Instruction_OUT
);
  logic [RENISS_WIDTH-1:0] data [DEPTH];
  logic [RENISS_WIDTH-1:0] woken [DEPTH+1];
  logic [DEPTH:0]          valid;
  logic [DEPTH-1:0]        ready;
  logic [CNT_W-1:0]        count, sel, wp;
  logic                    found, issue, push_acc;
  assign woken[DEPTH] = '0;
  assign valid[DEPTH] = 1'b0;
  // lowest-index ready slot is the oldest ready instruction
  always_comb begin
    found = 1'b0;
    sel = '0;
    IQLSQ_popData_OUT = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i]) begin
        found = 1'b1;
        sel = CNT_W'(i);
        IQLSQ_popData_OUT = data[i];
      end
  end
  assign Valid_Instruction_OUT = found;
  assign Mem_Instruction_OUT   = IQLSQ_popData_OUT[MEMRD] | IQLSQ_popData_OUT[MEMWR];
  assign issue    = found & !FREEZE & !FLUSH;
  assign push_acc = push_IN & (count < CNT_W'(DEPTH));
  assign wp       = count - CNT_W'(issue);
  assign full_OUT  = count == CNT_W'(DEPTH);
  assign count_OUT = count;
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    iq_entry #(.W(RENISS_WIDTH)) u_entry (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
      .wakeup_flag_IN(wakeup_flag_IN), .wakeup_index_IN(wakeup_index_IN),
      .shift(issue && CNT_W'(g) >= sel), .write(push_acc && wp == CNT_W'(g)),
      .up_data(woken[g+1]), .up_valid(valid[g+1]), .push_data(pushData_IN),
      .data(data[g]), .woken(woken[g]), .valid(valid[g]), .ready(ready[g])
    );
  end
  // occupancy count tracks accepted pushes minus issues
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) count <= '0;
    else count <= FLUSH ? '0 : count + CNT_W'(push_acc) - CNT_W'(issue);
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: scenario and random checks against a queue-based reference model
module tb_issue_queue;
  localparam int W = 137;
  localparam int D = 8;
  logic CLK = 1'b0, RESET, FREEZE, FLUSH, push_IN, wakeup_flag_IN;
  logic [W-1:0] pushData_IN, IQLSQ_popData_OUT;
  logic [5:0] wakeup_index_IN;
  logic full_OUT, Valid_Instruction_OUT, Mem_Instruction_OUT;
  logic [3:0] count_OUT;
  int errs = 0, checks = 0;
  logic [W-1:0] mq[$];

  issue_queue dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH), .push_IN(push_IN),
    .pushData_IN(pushData_IN), .full_OUT(full_OUT), .count_OUT(count_OUT),
    .wakeup_flag_IN(wakeup_flag_IN), .wakeup_index_IN(wakeup_index_IN),
    .IQLSQ_popData_OUT(IQLSQ_popData_OUT), .Valid_Instruction_OUT(Valid_Instruction_OUT),
    .Mem_Instruction_OUT(Mem_Instruction_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] mk(bit r1, int t1, bit r2, int t2, bit imm, bit mem);
    logic [W-1:0] p;
    p = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    p[82] = r1; p[81:76] = t1[5:0]; p[89] = r2; p[88:83] = t2[5:0];
    p[97] = imm; p[98] = mem; p[99] = 1'b0;
    return p;
  endfunction

  function automatic logic [W-1:0] wake(logic [W-1:0] p, logic f, logic [5:0] i);
    if (f && p[81:76] == i) p[82] = 1'b1;
    if (f && p[88:83] == i) p[89] = 1'b1;
    return p;
  endfunction

  function automatic int msel();
    foreach (mq[i]) if (mq[i][82] && (mq[i][89] || mq[i][97])) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] mpop();
    int s;
    s = msel();
    return (s < 0) ? '0 : mq[s];
  endfunction

  task automatic step(input logic p, input logic [W-1:0] d, input logic wf, input logic [5:0] wi,
                      input logic fr, input logic fl);
    int s, n;
    push_IN = p; pushData_IN = d; wakeup_flag_IN = wf; wakeup_index_IN = wi; FREEZE = fr; FLUSH = fl;
    s = msel();
    n = mq.size();
    @(posedge CLK);
    if (fl) mq.delete();
    else begin
      if (s >= 0 && !fr) mq.delete(s);
      if (p && n < D) mq.push_back(d);
      foreach (mq[i]) mq[i] = wake(mq[i], wf, wi);
    end
    #1;
    push_IN = 0; wakeup_flag_IN = 0; FREEZE = 0; FLUSH = 0;
  endtask

  task automatic test_reset();
    checks++; if (Valid_Instruction_OUT !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", Valid_Instruction_OUT); end
    checks++; if (count_OUT !== 4'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count_OUT); end
    checks++; if (IQLSQ_popData_OUT !== '0) begin errs++; $display("FAIL reset_pop got %h want 0", IQLSQ_popData_OUT); end
    checks++; if (full_OUT !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", full_OUT); end
  endtask

  task automatic test_in_order();
    logic [W-1:0] a[3];
    for (int k = 0; k < 3; k++) begin
      a[k] = mk(1, 0, 1, 0, 0, 0);
      step(1, a[k], 0, 0, 1, 0);
    end
    checks++; if (count_OUT !== 4'd3) begin errs++; $display("FAIL order_count got %0d want 3", count_OUT); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (IQLSQ_popData_OUT !== a[k] || Valid_Instruction_OUT !== 1'b1) begin errs++; $display("FAIL order_pop%0d got %h want %h", k, IQLSQ_popData_OUT, a[k]); end
      step(0, '0, 0, 0, 0, 0);
    end
    checks++; if (count_OUT !== 4'd0) begin errs++; $display("FAIL order_drain got %0d want 0", count_OUT); end
  endtask

  task automatic test_wakeup();
    logic [W-1:0] a, b;
    a = mk(0, 5, 1, 0, 0, 0);
    b = mk(1, 1, 1, 0, 0, 0);
    step(1, a, 0, 0, 0, 0);
    step(1, b, 0, 0, 0, 0);
    checks++; if (IQLSQ_popData_OUT !== b) begin errs++; $display("FAIL wake_b_first got %h want %h", IQLSQ_popData_OUT, b); end
    step(0, '0, 0, 0, 0, 0);
    wakeup_flag_IN = 1; wakeup_index_IN = 6'd5; #1;
    checks++; if (Valid_Instruction_OUT !== 1'b0) begin errs++; $display("FAIL wake_same_cycle got %b want 0", Valid_Instruction_OUT); end
    step(0, '0, 1, 5, 0, 0);
    checks++; if (Valid_Instruction_OUT !== 1'b1 || IQLSQ_popData_OUT !== wake(a, 1, 5)) begin errs++; $display("FAIL wake_a_next got %b/%h want 1/%h", Valid_Instruction_OUT, IQLSQ_popData_OUT, wake(a, 1, 5)); end
    step(0, '0, 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd0) begin errs++; $display("FAIL wake_drain got %0d want 0", count_OUT); end
  endtask

  task automatic test_full();
    for (int k = 0; k < D; k++) step(1, mk(0, 63, 1, 0, 0, 0), 0, 0, 0, 0);
    checks++; if (full_OUT !== 1'b1 || count_OUT !== 4'd8) begin errs++; $display("FAIL full_flag got %b/%0d want 1/8", full_OUT, count_OUT); end
    step(1, mk(1, 0, 1, 0, 0, 0), 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd8 || Valid_Instruction_OUT !== 1'b0) begin errs++; $display("FAIL full_drop got %0d/%b want 8/0", count_OUT, Valid_Instruction_OUT); end
    step(0, '0, 1, 63, 0, 0);
    checks++; if (IQLSQ_popData_OUT !== mpop()) begin errs++; $display("FAIL full_oldest got %h want %h", IQLSQ_popData_OUT, mpop()); end
    step(1, mk(1, 0, 1, 0, 0, 0), 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd7 || full_OUT !== 1'b0) begin errs++; $display("FAIL full_push_issue got %0d want 7", count_OUT); end
    step(0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_bypass();
    logic [W-1:0] e;
    e = mk(1, 0, 0, 9, 0, 0);
    step(1, e, 1, 9, 0, 0);
    checks++; if (Valid_Instruction_OUT !== 1'b1 || IQLSQ_popData_OUT !== wake(e, 1, 9)) begin errs++; $display("FAIL bypass got %b/%h want 1/%h", Valid_Instruction_OUT, IQLSQ_popData_OUT, wake(e, 1, 9)); end
    step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_imm();
    step(1, mk(1, 0, 0, 12, 1, 1), 0, 0, 0, 0);
    checks++; if (Valid_Instruction_OUT !== 1'b1 || Mem_Instruction_OUT !== 1'b1) begin errs++; $display("FAIL imm got %b/%b want 1/1", Valid_Instruction_OUT, Mem_Instruction_OUT); end
    step(0, '0, 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd0) begin errs++; $display("FAIL imm_issue got %0d want 0", count_OUT); end
  endtask

  task automatic test_freeze();
    logic [W-1:0] f;
    f = mk(1, 0, 1, 0, 0, 0);
    step(1, f, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) step(1, mk(1, 0, 1, 0, 0, 0), 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, mk(1, 0, 1, 0, 0, 0), 0, 0, 1, 0);
      checks++; if (IQLSQ_popData_OUT !== f || count_OUT !== 4'(4 + k)) begin errs++; $display("FAIL freeze%0d got %h/%0d want %h/%0d", k, IQLSQ_popData_OUT, count_OUT, f, 4 + k); end
    end
    for (int k = 0; k < 10 && mq.size() > 0; k++) begin
      checks++; if (IQLSQ_popData_OUT !== mpop()) begin errs++; $display("FAIL freeze_drain%0d got %h want %h", k, IQLSQ_popData_OUT, mpop()); end
      step(0, '0, 0, 0, 0, 0);
    end
    checks++; if (count_OUT !== 4'd0) begin errs++; $display("FAIL freeze_empty got %0d want 0", count_OUT); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) step(1, mk(0, 40, 0, 41, 0, 0), 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd5) begin errs++; $display("FAIL flush_fill got %0d want 5", count_OUT); end
    step(1, mk(1, 0, 1, 0, 0, 0), 1, 40, 0, 1);
    checks++; if (count_OUT !== 4'd0 || Valid_Instruction_OUT !== 1'b0) begin errs++; $display("FAIL flush got %0d/%b want 0/0", count_OUT, Valid_Instruction_OUT); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 5) == 0, $urandom_range(0, 1)),
           $urandom_range(0, 1), 6'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
      checks++; if (count_OUT !== 4'(mq.size())) begin errs++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count_OUT, mq.size()); end
      checks++; if (Valid_Instruction_OUT !== (msel() >= 0)) begin errs++; $display("FAIL rnd_valid c=%0d got %b want %b", c, Valid_Instruction_OUT, msel() >= 0); end
      checks++; if (IQLSQ_popData_OUT !== mpop()) begin errs++; $display("FAIL rnd_pop c=%0d got %h want %h", c, IQLSQ_popData_OUT, mpop()); end
      checks++; if (full_OUT !== (mq.size() == D)) begin errs++; $display("FAIL rnd_full c=%0d got %b want %b", c, full_OUT, mq.size() == D); end
      checks++; if (Mem_Instruction_OUT !== (mpop()[98] | mpop()[99])) begin errs++; $display("FAIL rnd_mem c=%0d got %b", c, Mem_Instruction_OUT); end
    end
  endtask

  task automatic test_async_reset();
    step(0, '0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, mk(1, 0, 1, 0, 0, 0), 0, 0, 1, 0);
    checks++; if (Valid_Instruction_OUT !== 1'b1) begin errs++; $display("FAIL areset_pre got %b want 1", Valid_Instruction_OUT); end
    #2; push_IN = 1; pushData_IN = mk(1, 0, 1, 0, 0, 0); RESET = 0; #1;
    checks++; if (Valid_Instruction_OUT !== 1'b0 || count_OUT !== 4'd0) begin errs++; $display("FAIL areset got %b/%0d want 0/0", Valid_Instruction_OUT, count_OUT); end
    mq.delete();
    #2; push_IN = 0; RESET = 1;
    step(0, '0, 0, 0, 0, 0);
    checks++; if (count_OUT !== 4'd0 || Valid_Instruction_OUT !== 1'b0) begin errs++; $display("FAIL areset_after got %0d/%b want 0/0", count_OUT, Valid_Instruction_OUT); end
  endtask

  initial begin
    RESET = 0; FREEZE = 0; FLUSH = 0; push_IN = 0; pushData_IN = '0; wakeup_flag_IN = 0; wakeup_index_IN = '0;
    #12;
    test_reset();
    RESET = 1;
    @(posedge CLK); #1;
    test_in_order();
    test_wakeup();
    test_full();
    test_bypass();
    test_imm();
    test_freeze();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
